ram_arbiter: RTL and testbench

//  Shares the single-port data RAM between two requesters: port 0 (CPU load/store) and port 1 (loader/debug DMA).

---
 rtl/ram_arbiter_pkg.sv | 27 ++
 rtl/ram_arbiter_rr_pick2.sv | 24 ++
 rtl/ram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared constants and types for the two-port RAM arbiter.
// RAM command encodings, port identifiers and the lock counter helper live here
// so the top and the picker agree on one encoding.
package ram_arbiter_pkg;

  localparam logic RstEnable = 1'b1;
  localparam logic RamRead   = 1'b1;
  localparam logic RamWrite  = 1'b0;
  localparam logic Port0     = 1'b0;
  localparam logic Port1     = 1'b1;

  // Width of the consecutive-locked-grant counter (lock build only).
  localparam int LockCntW = 4;

  // Control half of the registered RAM command stage.
  typedef struct packed {
    logic cs;     // command valid on the RAM pins
    logic rw;     // RamRead / RamWrite
    logic owner;  // port that issued the command
  } issue_ctl_t;

  // Saturating increment for the lock counter.
  function automatic logic [LockCntW-1:0] sat_inc(input logic [LockCntW-1:0] v);
    return (&v) ? v : v + LockCntW'(1);
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
// On a tie the port that did not win last time is chosen.
module ram_arbiter_rr_pick2
  import ram_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic win,
  output logic any
);

  // Pick the winner from the two requests and the previous winner.
  always_comb begin
    win = Port0;
    any = req0 | req1;
    if (req0 && req1) begin
      win = ~last;
    end else if (req1) begin
      win = Port1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port data RAM.
// Port 0 is the CPU load/store port, port 1 the loader/debug DMA port.
// Grants are combinational; the RAM command is registered one cycle after the
// grant and read data is registered one cycle later, so rvalid follows a read
// grant by exactly two cycles.  One access is accepted per cycle.
// Optional feature: define RAM_ARB_LOCK_EN to let a requester hold the grant
// with its lock input for up to LOCK_MAX consecutive grants.
//
// Handshake: gnt_i is high in the cycle a request is accepted; the requester
// may change req/we/addr/wdata in the next cycle.  rvalid_i is a one-cycle
// pulse with rdata_i valid in that cycle and zero otherwise; it cannot be
// stalled.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          ram_cs,
  output logic          ram_rw,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  logic          last_q, last_d;
  issue_ctl_t    issue_q, issue_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic pick_win, pick_any;
  logic win, any_win, grant;

  ram_arbiter_rr_pick2 u_rr_pick2 (
    .req0 (req0),
    .req1 (req1),
    .last (last_q),
    .win  (pick_win),
    .any  (pick_any)
  );

`ifdef RAM_ARB_LOCK_EN
  localparam logic [LockCntW-1:0] LockMaxC = LockCntW'(LOCK_MAX);

  logic [LockCntW-1:0] lock_cnt_q, lock_cnt_d;
  logic                hold_req, hold_lock, lock_hold, win_lock;

  // A locked run keeps the last winner in front of the round-robin picker
  // until it drops req/lock or has used up LOCK_MAX grants in a row.
  always_comb begin
    hold_req   = (last_q == Port1) ? req1 : req0;
    hold_lock  = (last_q == Port1) ? lock1 : lock0;
    lock_hold  = (lock_cnt_q != '0) && (lock_cnt_q < LockMaxC) && hold_req && hold_lock;
    win        = lock_hold ? last_q : pick_win;
    any_win    = pick_any;
    win_lock   = (win == Port1) ? lock1 : lock0;
    lock_cnt_d = '0;
    if (any_win && win_lock) begin
      // Continuing a run counts up; any other locked grant starts a new run.
      lock_cnt_d = lock_hold ? sat_inc(lock_cnt_q) : LockCntW'(1);
    end
  end

  // Lock counter register.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      lock_cnt_q <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end
`else
  logic unused_lock;

  // Pure round-robin: lock inputs have no effect.
  always_comb begin
    win         = pick_win;
    any_win     = pick_any;
    unused_lock = lock0 ^ lock1 ^ (LOCK_MAX == 0);
  end
`endif

  assign grant = any_win && (rst != RstEnable);
  assign gnt0  = grant && (win == Port0);
  assign gnt1  = grant && (win == Port1);

  // Next values for the command stage and the read-return stage.
  always_comb begin
    last_d      = last_q;
    issue_d     = '{cs: 1'b0, rw: RamRead, owner: Port0};
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (any_win) begin
      last_d        = win;
      issue_d.cs    = 1'b1;
      issue_d.owner = win;
      if (win == Port1) begin
        issue_d.rw  = we1 ? RamWrite : RamRead;
        ram_addr_d  = addr1;
        ram_wdata_d = wdata1;
      end else begin
        issue_d.rw  = we0 ? RamWrite : RamRead;
        ram_addr_d  = addr0;
        ram_wdata_d = wdata0;
      end
    end
    // The RAM is presenting data for the read issued last cycle.
    rvalid0_d = issue_q.cs && (issue_q.rw == RamRead) && (issue_q.owner == Port0);
    rvalid1_d = issue_q.cs && (issue_q.rw == RamRead) && (issue_q.owner == Port1);
    rdata0_d  = rvalid0_d ? ram_rdata : '0;
    rdata1_d  = rvalid1_d ? ram_rdata : '0;
  end

  // Command and return registers; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      last_q      <= Port1;
      issue_q     <= '{cs: 1'b0, rw: RamRead, owner: Port0};
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      last_q      <= last_d;
      issue_q     <= issue_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign ram_cs    = issue_q.cs;
  assign ram_rw    = issue_q.rw;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter (build with +define+RAM_ARB_LOCK_EN for the lock variant).
module tb_ram_arbiter;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int LOCK_MAX = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_cs, ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  ram_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 1) return 32'hA5A5A5A5;
    return 32'h5A000000 ^ (i * 32'h01010101);
  endfunction

  // ---------------- bench RAM (32 words, addr[6:2]) ----------------
  logic [DW-1:0] mem [32];
  assign ram_rdata = mem[ram_addr[6:2]];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (ram_cs === 1'b1 && ram_rw === 1'b0) mem[ram_addr[6:2]] <= ram_wdata;
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem [32];
  logic          m_last, m_cs, m_rw;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit            m_run_port;
  int            m_run_len;
  int            cyc;
  logic [DW-1:0] exp_q[$];      // expected read data, in return order
  int            exp_due_q[$];  // cycle in which it must appear
  bit            exp_port_q[$]; // port it belongs to

  int checks = 0;
  int errors = 0;
  logic          obs_gnt0, obs_gnt1, obs_rvalid0, obs_cs;
  logic [DW-1:0] obs_rdata0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h, required 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete(); exp_due_q.delete(); exp_port_q.delete();
    m_last = 1'b1; m_cs = 1'b0; m_rw = 1'b1; m_addr = '0; m_wdata = '0;
    m_run_port = 1'b0; m_run_len = 0;
  endtask

  // Winner according to the arbitration rules, from the current inputs.
  task automatic model_win(output bit has, output bit w, output bit cont);
    bit hold = 1'b0;
    has = 1'b0; w = 1'b0; cont = 1'b0;
    if (rst) return;
`ifdef RAM_ARB_LOCK_EN
    hold = (m_run_len > 0) && (m_run_len < LOCK_MAX) &&
           (m_run_port ? (req1 && lock1) : (req0 && lock0));
`endif
    if (hold) begin has = 1'b1; w = m_run_port; end
    else if (req0 && req1) begin has = 1'b1; w = !m_last; end
    else if (req0) begin has = 1'b1; w = 1'b0; end
    else if (req1) begin has = 1'b1; w = 1'b1; end
    cont = has && (w == m_run_port) && (m_run_len > 0) && (m_run_len < LOCK_MAX);
  endtask

  // ---------------- driver ----------------
  task automatic set_in(input bit r0, input bit r1, input bit w0, input bit w1,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input bit l0, input bit l1);
    req0 = r0; req1 = r1; we0 = w0; we1 = w1; addr0 = a0; addr1 = a1;
    wdata0 = d0; wdata1 = d1; lock0 = l0; lock1 = l1;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, '0, '0, '0, '0, 0, 0);
  endtask

  // One clock cycle: compare at negedge, then advance the model at posedge.
  task automatic step();
    bit has, w, cont, wl, wwe;
    logic          e_rv0, e_rv1;
    logic [DW-1:0] e_rd0, e_rd1, wd;
    logic [AW-1:0] wa;
    @(negedge clk);
    model_win(has, w, cont);
    check("gnt0", gnt0, has && !w);
    check("gnt1", gnt1, has && w);
    e_rv0 = 0; e_rv1 = 0; e_rd0 = '0; e_rd1 = '0;
    if (exp_q.size() > 0 && exp_due_q[0] == cyc) begin
      if (exp_port_q[0]) begin e_rv1 = 1; e_rd1 = exp_q[0]; end
      else begin e_rv0 = 1; e_rd0 = exp_q[0]; end
      void'(exp_q.pop_front()); void'(exp_due_q.pop_front()); void'(exp_port_q.pop_front());
    end
    check("rvalid0", rvalid0, e_rv0);
    check("rvalid1", rvalid1, e_rv1);
    check("rdata0", rdata0, e_rd0);
    check("rdata1", rdata1, e_rd1);
    check("ram_cs", ram_cs, m_cs);
    check("ram_rw", ram_rw, m_rw);
    check("ram_addr", ram_addr, m_addr);
    check("ram_wdata", ram_wdata, m_wdata);
    obs_gnt0 = gnt0; obs_gnt1 = gnt1; obs_rvalid0 = rvalid0; obs_rdata0 = rdata0; obs_cs = ram_cs;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (has) begin
      wwe = w ? we1 : we0;  wa = w ? addr1 : addr0;
      wd  = w ? wdata1 : wdata0;  wl = w ? lock1 : lock0;
      if (wwe) m_mem[wa[6:2]] = wd;
      else begin exp_q.push_back(m_mem[wa[6:2]]); exp_due_q.push_back(cyc + 2); exp_port_q.push_back(w); end
      m_cs = 1'b1; m_rw = !wwe; m_addr = wa; m_wdata = wd; m_last = w;
      if (wl) begin m_run_len = cont ? m_run_len + 1 : 1; m_run_port = w; end
      else m_run_len = 0;
    end else begin
      m_cs = 1'b0; m_rw = 1'b1; m_run_len = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; step(); rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit r0, r1, w0, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    bit g0, g1;
  } vec_t;

  vec_t vecs [10];
  bit   exp_lock [10];

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = init_word(i);
    cyc = 0;
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();

    // Reset state (explicit) while rst is held.
    step();
    check("reset_cs", obs_cs, 1'b0);
    check("reset_rvalid0", obs_rvalid0, 1'b0);
    rst = 1'b0;

    // Read of 0x04 by port 0 returns RAM[1] two cycles after the grant.
    set_in(1, 0, 0, 0, 32'h04, '0, '0, '0, 0, 0); step();
    check("t1_gnt0", obs_gnt0, 1'b1);
    idle(); step(); step();
    check("t1_rvalid0", obs_rvalid0, 1'b1);
    check("t1_rdata0", obs_rdata0, 32'hA5A5A5A5);

    // Table: tie alternation from reset, idle cycles, single-port accesses.
    do_reset();
    vecs[0] = '{1, 1, 0, 0, 32'h10, 32'h14, '0, '0, 1, 0};
    vecs[1] = '{1, 1, 0, 0, 32'h10, 32'h14, '0, '0, 0, 1};
    vecs[2] = '{1, 1, 0, 0, 32'h10, 32'h14, '0, '0, 1, 0};
    vecs[3] = '{1, 1, 0, 0, 32'h10, 32'h14, '0, '0, 0, 1};
    vecs[4] = '{0, 0, 0, 0, '0, '0, '0, '0, 0, 0};
    vecs[5] = '{0, 0, 0, 0, '0, '0, '0, '0, 0, 0};
    vecs[6] = '{0, 0, 0, 0, '0, '0, '0, '0, 0, 0};
    vecs[7] = '{0, 1, 0, 1, '0, 32'h20, '0, 32'hCAFEF00D, 0, 1};
    vecs[8] = '{1, 0, 0, 0, 32'h20, '0, '0, '0, 1, 0};
    vecs[9] = '{0, 0, 0, 0, '0, '0, '0, '0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].r0, vecs[i].r1, vecs[i].w0, vecs[i].w1, vecs[i].a0, vecs[i].a1,
             vecs[i].d0, vecs[i].d1, 0, 0);
      step();
      check($sformatf("tbl%0d_gnt0", i), obs_gnt0, vecs[i].g0);
      check($sformatf("tbl%0d_gnt1", i), obs_gnt1, vecs[i].g1);
    end
    idle(); step(); step();

    // Write by port 1 then read-after-write by port 0 on the next cycle.
    set_in(0, 1, 0, 1, '0, 32'h08, '0, 32'h12345678, 0, 0); step();
    set_in(1, 0, 0, 0, 32'h08, '0, '0, '0, 0, 0); step();
    check("t3_gnt0", obs_gnt0, 1'b1);
    idle(); step(); step();
    check("t3_rvalid0", obs_rvalid0, 1'b1);
    check("t3_rdata0", obs_rdata0, 32'h12345678);

    // Reset in the cycle after a read grant discards the return.
    set_in(1, 0, 0, 0, 32'h04, '0, '0, '0, 0, 0); step();
    idle(); rst = 1'b1; step(); rst = 1'b0;
    step();
    check("t4_rvalid0", obs_rvalid0, 1'b0);
    check("t4_cs", obs_cs, 1'b0);
    step();
    check("t4_rvalid0_late", obs_rvalid0, 1'b0);

    // Port 0 holding lock with port 1 also requesting.
    do_reset();
    for (int i = 0; i < 10; i++) begin
`ifdef RAM_ARB_LOCK_EN
      exp_lock[i] = (i != 8);
`else
      exp_lock[i] = (i % 2 == 0);
`endif
    end
    for (int i = 0; i < 10; i++) begin
      set_in(1, 1, 0, 0, 32'h30, 32'h34, '0, '0, 1, 0);
      step();
      check($sformatf("t5_gnt0_%0d", i), obs_gnt0, exp_lock[i]);
    end
    idle(); step(); step();

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 500; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 1), $urandom_range(0, 1),
             AW'($urandom_range(0, 127)), AW'($urandom_range(0, 127)),
             $urandom, $urandom,
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0; idle(); step(); step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
